// File: rtl/lane_gather16_if.sv
// lane_gather16_if: operand stream in, packed lane vector out, both valid/ready
interface lane_gather16_if #(parameter int WIDTH = 32, parameter int LANES = 16);
  logic                   in_valid;
  logic                   in_ready;
  logic [WIDTH-1:0]       in_data;
  logic                   in_last;
  logic                   out_valid;
  logic                   out_ready;
  logic [WIDTH-1:0]       out_data [LANES];
  logic [$clog2(LANES):0] out_count;
  modport master (output in_valid, in_data, in_last, out_ready,
                  input  in_ready, out_valid, out_data, out_count);
  modport slave  (input  in_valid, in_data, in_last, out_ready,
                  output in_ready, out_valid, out_data, out_count);
endinterface

// File: rtl/lane_gather16.sv
// lane_gather16: double-buffered gatherer packing a stream of operands into LANES-wide vectors
module lane_gather16 #(
  parameter int WIDTH = 32,
  parameter int LANES = 16
) (
  input logic clk,
  input logic rst,
  lane_gather16_if.slave bus
);
  localparam int IW = $clog2(LANES);
  localparam int CW = IW + 1;
  localparam logic [IW-1:0] LAST = IW'(LANES - 1);
  logic [IW-1:0]    r_idx;
  logic             r_pend;
  logic [CW-1:0]    r_pcnt;
  logic             r_ov;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_fill [LANES];
  logic [WIDTH-1:0] r_out  [LANES];
  logic [WIDTH-1:0] w_vec  [LANES];
  logic             w_acc, w_close, w_push, w_free;
  logic [CW-1:0]    w_ccnt;
  assign w_acc   = bus.in_valid & ~r_pend;
  assign w_close = w_acc & (bus.in_last | (r_idx == LAST));
  assign w_push  = r_ov & bus.out_ready;
  assign w_free  = ~r_ov | bus.out_ready;
  assign w_ccnt  = CW'(r_idx) + CW'(1);
  // lanes above idx are already zero because the fill bank is cleared on every close
  for (genvar i = 0; i < LANES; i++) begin : g_vec
    assign w_vec[i] = (r_idx == IW'(i)) ? bus.in_data : r_fill[i];
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_idx  <= '0;
      r_pend <= 1'b0;
      r_pcnt <= '0;
      r_ov   <= 1'b0;
      r_cnt  <= '0;
      r_fill <= '{default: '0};
      r_out  <= '{default: '0};
    end else if (r_pend) begin
      if (w_push) begin
        r_out  <= r_fill;
        r_cnt  <= r_pcnt;
        r_pend <= 1'b0;
        r_idx  <= '0;
        r_fill <= '{default: '0};
      end
    end else if (w_close && w_free) begin
      r_out  <= w_vec;
      r_cnt  <= w_ccnt;
      r_ov   <= 1'b1;
      r_idx  <= '0;
      r_fill <= '{default: '0};
    end else if (w_close) begin
      r_fill[r_idx] <= bus.in_data;
      r_pend        <= 1'b1;
      r_pcnt        <= w_ccnt;
    end else begin
      if (w_acc) begin
        r_fill[r_idx] <= bus.in_data;
        r_idx         <= r_idx + IW'(1);
      end
      if (w_push) r_ov <= 1'b0;
    end
  assign bus.in_ready  = ~r_pend;
  assign bus.out_valid = r_ov;
  assign bus.out_data  = r_out;
  assign bus.out_count = r_cnt;
endmodule
